// File: rtl/shared_arb_pkg.sv
// rtl/shared_arb_pkg.sv - shared types, constants and round-robin pick for shared_unit_arbiter
package shared_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int STAT_W  = 16;
    localparam int MAX_REQ = 16;
    localparam int PICK_W  = 4;

    // First set bit at or above ptr, wrapping within the n active requesters.
    function automatic logic [PICK_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [PICK_W-1:0]  ptr,
        input int                 n
    );
        logic [PICK_W-1:0] win;
        logic              found;
        int                idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (!found && (i < n)) begin
                idx = (int'(ptr) + i) % n;
                if (req[idx]) begin
                    win   = PICK_W'(idx);
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/shared_adder.sv
// rtl/shared_adder.sv - combinational widened adder used as the shared compute unit
module shared_adder #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 11,
    parameter int SUM_W  = 20
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [HEIGHT-1:0] b,
    output logic [SUM_W-1:0]  sum
);

    localparam int EXT_W = ((WIDTH > HEIGHT) ? WIDTH : HEIGHT) + 1;

    logic [EXT_W-1:0] ext;

    // Full-precision sum first; narrowing to SUM_W wraps by design.
    assign ext = EXT_W'(a) + EXT_W'(b);
    assign sum = SUM_W'(ext);

endmodule

// File: rtl/shared_unit_arbiter.sv
// rtl/shared_unit_arbiter.sv - round-robin sequencer sharing one adder; SHARED_ARB_STATS_EN adds grant counters
module shared_unit_arbiter
    import shared_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 10,
    parameter int HEIGHT    = 11,
    parameter int SUM_W     = 20,
    parameter int OP_CYCLES = 2,
    localparam int IDX_W    = $clog2(N_REQ),
    localparam int CNT_W    = (OP_CYCLES > 1) ? $clog2(OP_CYCLES) : 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   op_a,
    input  logic [N_REQ*HEIGHT-1:0]  op_b,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic                     resp_valid,
    output logic [IDX_W-1:0]         resp_id,
    output logic [SUM_W-1:0]         resp_sum,
    input  logic                     resp_ready
`ifdef SHARED_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0]  grant_count
`endif
);

    arb_state_t        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  id_q;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  a_q;
    logic [HEIGHT-1:0] b_q;
    logic [SUM_W-1:0]  sum_d;
    logic [SUM_W-1:0]  sum_q;
    logic              take;

    assign winner = IDX_W'(rr_pick(MAX_REQ'(req), PICK_W'(rr_ptr), N_REQ));

    // Reset gates the grant so nothing is accepted while the block is held in reset.
    assign take = reset_n && (state == IDLE) && (|req);

    always_comb begin
        grant = '0;
        if (take) begin
            grant[winner] = 1'b1;
        end
    end

    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP);
    assign resp_id    = id_q;
    assign resp_sum   = sum_q;

    shared_adder #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .SUM_W  (SUM_W)
    ) u_adder (
        .a   (a_q),
        .b   (b_q),
        .sum (sum_d)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        a_q    <= op_a[winner*WIDTH +: WIDTH];
                        b_q    <= op_b[winner*HEIGHT +: HEIGHT];
                        id_q   <= winner;
                        rr_ptr <= (winner == IDX_W'(N_REQ-1)) ? '0 : winner + 1'b1;
                        cnt    <= CNT_W'(OP_CYCLES-1);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        sum_q <= sum_d;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHARED_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [N_REQ];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else if (take && (stat_q[winner] != '1)) begin
            stat_q[winner] <= stat_q[winner] + 1'b1;
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_count[i*STAT_W +: STAT_W] = stat_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// tb/tb_shared_unit_arbiter.sv - directed vector bench for shared_unit_arbiter
module tb_shared_unit_arbiter;

    logic        clock;
    logic        reset_n;
    logic [3:0]  req;
    logic [39:0] op_a;
    logic [43:0] op_b;
    logic        resp_ready;
    logic [3:0]  grant;
    logic        busy;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [19:0] resp_sum;
    logic [3:0]  grant11;
    logic        busy11;
    logic        resp_valid11;
    logic [1:0]  resp_id11;
    logic [10:0] resp_sum11;
`ifdef SHARED_ARB_STATS_EN
    logic [63:0] grant_count;
    logic [63:0] grant_count11;
`endif

    shared_unit_arbiter #(
        .N_REQ(4), .WIDTH(10), .HEIGHT(11), .SUM_W(20), .OP_CYCLES(2)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .grant       (grant),
        .busy        (busy),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_sum    (resp_sum),
        .resp_ready  (resp_ready)
`ifdef SHARED_ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    shared_unit_arbiter #(
        .N_REQ(4), .WIDTH(10), .HEIGHT(11), .SUM_W(11), .OP_CYCLES(2)
    ) dut11 (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .grant       (grant11),
        .busy        (busy11),
        .resp_valid  (resp_valid11),
        .resp_id     (resp_id11),
        .resp_sum    (resp_sum11),
        .resp_ready  (resp_ready)
`ifdef SHARED_ARB_STATS_EN
        ,
        .grant_count (grant_count11)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  exp_grant;
        logic [1:0]  exp_id;
        logic [19:0] exp_sum;
    } vec_t;

    vec_t vecs [10];
    int   n_pass;
    int   n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full transaction from IDLE with resp_ready high; ends back in IDLE.
    task automatic do_op(input string name, input logic [3:0] exp_grant,
                         input logic [1:0] exp_id, input logic [19:0] exp_sum);
        int lat;
        chk({name, " grant"}, 32'(grant), 32'(exp_grant));
        chk({name, " idle busy"}, 32'(busy), 32'd0);
        tick();
        chk({name, " busy"}, 32'(busy), 32'd1);
        chk({name, " busy grant"}, 32'(grant), 32'd0);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'd3);
        chk({name, " id"}, 32'(resp_id), 32'(exp_id));
        chk({name, " sum"}, 32'(resp_sum), 32'(exp_sum));
        chk({name, " sum11"}, 32'(resp_sum11), 32'(exp_sum[10:0]));
        chk({name, " resp grant"}, 32'(grant), 32'd0);
        tick();
    endtask

    initial begin
        logic any_valid;
        int   lat;
        n_pass  = 0;
        n_total = 0;

        op_a = {10'd1023, 10'd100, 10'd17, 10'd5};
        op_b = {11'd2047, 11'd200, 11'd300, 11'd9};

        vecs[0] = '{4'b1111, 4'b0001, 2'd0, 20'd14};
        vecs[1] = '{4'b1111, 4'b0010, 2'd1, 20'd317};
        vecs[2] = '{4'b1111, 4'b0100, 2'd2, 20'd300};
        vecs[3] = '{4'b1111, 4'b1000, 2'd3, 20'd3070};
        vecs[4] = '{4'b1111, 4'b0001, 2'd0, 20'd14};
        vecs[5] = '{4'b0100, 4'b0100, 2'd2, 20'd300};
        vecs[6] = '{4'b0001, 4'b0001, 2'd0, 20'd14};
        vecs[7] = '{4'b1001, 4'b1000, 2'd3, 20'd3070};
        vecs[8] = '{4'b0110, 4'b0010, 2'd1, 20'd317};
        vecs[9] = '{4'b0010, 4'b0010, 2'd1, 20'd317};

        reset_n    = 1'b0;
        req        = 4'b1111;
        resp_ready = 1'b1;
        #1;
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset valid", 32'(resp_valid), 32'd0);
        chk("reset id", 32'(resp_id), 32'd0);
        chk("reset sum", 32'(resp_sum), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            req = vecs[i].req;
            #1;
            do_op($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_id, vecs[i].exp_sum);
        end

        // Stall in RESP for 5 cycles with req held
        req        = 4'b0100;
        resp_ready = 1'b0;
        #1;
        chk("stall grant", 32'(grant), 32'b0100);
        tick();
        lat = 1;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("stall latency", 32'(lat), 32'd3);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d valid", c), 32'(resp_valid), 32'd1);
            chk($sformatf("stall%0d sum", c), 32'(resp_sum), 32'd300);
            chk($sformatf("stall%0d id", c), 32'(resp_id), 32'd2);
            chk($sformatf("stall%0d grant", c), 32'(grant), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("handshake grant", 32'(grant), 32'd0);
        tick();
        chk("post handshake grant", 32'(grant), 32'b0100);
        req = 4'b0000;
        #1;
        chk("dropped req grant", 32'(grant), 32'd0);
        tick();
        chk("dropped req busy", 32'(busy), 32'd0);

        // Reset pulse mid-BUSY
        req = 4'b0010;
        #1;
        chk("pre-reset grant", 32'(grant), 32'b0010);
        tick();
        chk("pre-reset busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #2;
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst valid", 32'(resp_valid), 32'd0);
        chk("async rst id", 32'(resp_id), 32'd0);
        chk("async rst sum", 32'(resp_sum), 32'd0);
        chk("async rst grant", 32'(grant), 32'd0);
        req = 4'b0000;
        tick();
        reset_n = 1'b1;
        any_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            any_valid = any_valid | resp_valid;
        end
        chk("aborted op valid", 32'(any_valid), 32'd0);
        req = 4'b1111;
        #1;
        do_op("after reset", 4'b0001, 2'd0, 20'd14);

`ifdef SHARED_ARB_STATS_EN
        req = 4'b0010;
        #1;
        for (int k = 0; k < 6; k++) begin
            do_op($sformatf("stat%0d", k), 4'b0010, 2'd1, 20'd317);
        end
        chk("count req1", 32'(grant_count[31:16]), 32'd6);
        chk("count req0", 32'(grant_count[15:0]), 32'd1);
        force dut.stat_q[1] = 16'hFFFF;
        #1;
        release dut.stat_q[1];
        do_op("sat", 4'b0010, 2'd1, 20'd317);
        chk("count sat", 32'(grant_count[31:16]), 32'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
